// File: rtl/gate_sweep_checker.sv
// Sweeps every {a,b} operand pair onto a 2-input bitwise gate, waits a settle time,
// and checks the gate output against the selected function.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | waiting for start; no result held
// ST_DRIVE  | operands just updated, one cycle
// ST_SETTLE | holding operands for SETTLE cycles
// ST_SAMPLE | compare dut_out with expected, advance or finish
// ST_DONE   | result held (pass/err_count/first_fail) until restart
module gate_sweep_checker #(
    parameter int WIDTH  = 1,
    parameter int OP     = 1,
    parameter int SETTLE = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    output logic [WIDTH-1:0] dut_a,
    output logic [WIDTH-1:0] dut_b,
    input  logic [WIDTH-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic             fail_valid,
    output logic [WIDTH-1:0] first_fail_a,
    output logic [WIDTH-1:0] first_fail_b
);

    localparam int VW    = 2 * WIDTH;
    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SET_W-1:0] SETTLE_LOAD = (SETTLE > 0) ? SET_W'(SETTLE - 1) : '0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    state_t           state;
    logic [VW-1:0]    vec;
    logic [SET_W-1:0] settle_cnt;
    logic [WIDTH-1:0] exp_out;
    logic             mismatch;

    assign dut_a = vec[VW-1:WIDTH];
    assign dut_b = vec[WIDTH-1:0];

    always_comb begin
        case (OP)
            0:       exp_out = dut_a & dut_b;
            1:       exp_out = dut_a | dut_b;
            2:       exp_out = dut_a ^ dut_b;
            3:       exp_out = ~(dut_a & dut_b);
            default: exp_out = dut_a | dut_b;
        endcase
    end

    // Written so an unknown compare result falls through to "mismatch".
    always_comb begin
        mismatch = 1'b1;
        if (dut_out == exp_out)
            mismatch = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            vec          <= '0;
            settle_cnt   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            err_count    <= '0;
            fail_valid   <= 1'b0;
            first_fail_a <= '0;
            first_fail_b <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state        <= ST_DRIVE;
                        vec          <= '0;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        pass         <= 1'b0;
                        err_count    <= '0;
                        fail_valid   <= 1'b0;
                        first_fail_a <= '0;
                        first_fail_b <= '0;
                    end
                end
                ST_DRIVE: begin
                    if (SETTLE > 0) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= SETTLE_LOAD;
                    end else begin
                        state <= ST_SAMPLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == '0)
                        state <= ST_SAMPLE;
                    else
                        settle_cnt <= settle_cnt - 1'b1;
                end
                ST_SAMPLE: begin
                    if (mismatch) begin
                        if (err_count != '1)
                            err_count <= err_count + 1'b1;
                        if (!fail_valid) begin
                            fail_valid   <= 1'b1;
                            first_fail_a <= dut_a;
                            first_fail_b <= dut_b;
                        end
                    end
                    if (vec == '1) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == '0) && !mismatch;
                    end else begin
                        vec   <= vec + 1'b1;
                        state <= ST_DRIVE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench for gate_sweep_checker: four instances cover OR/AND functions,
// SETTLE=0 and a 2-bit saturating configuration, each fed by a bench-side gate model.
module tb_gate_sweep_checker;

    logic clock;
    logic reset;
    int   vectors;
    int   miscompares;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // u0: WIDTH=1, OP=OR, SETTLE=2, gate selected by mode0
    logic       start0;
    logic       a0, b0, out0;
    logic       busy0, done0, pass0, fv0, ffa0, ffb0;
    logic [7:0] err0;
    int         mode0;

    always_comb begin
        case (mode0)
            0:       out0 = a0 | b0;
            1:       out0 = 1'b0;
            2:       out0 = a0 & b0;
            default: out0 = ~(a0 | b0);
        endcase
    end

    gate_sweep_checker #(.WIDTH(1), .OP(1), .SETTLE(2), .CNT_W(8)) u0 (
        .clock(clock), .reset(reset), .start(start0),
        .dut_a(a0), .dut_b(b0), .dut_out(out0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .fail_valid(fv0), .first_fail_a(ffa0), .first_fail_b(ffb0)
    );

    // u1: WIDTH=1, OP=AND, SETTLE=2, driven by an AND gate
    logic       start1;
    logic       a1, b1, out1;
    logic       busy1, done1, pass1, fv1, ffa1, ffb1;
    logic [7:0] err1;
    assign out1 = a1 & b1;

    gate_sweep_checker #(.WIDTH(1), .OP(0), .SETTLE(2), .CNT_W(8)) u1 (
        .clock(clock), .reset(reset), .start(start1),
        .dut_a(a1), .dut_b(b1), .dut_out(out1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_valid(fv1), .first_fail_a(ffa1), .first_fail_b(ffb1)
    );

    // u2: WIDTH=1, OP=OR, SETTLE=0, correct OR gate
    logic       start2;
    logic       a2, b2, out2;
    logic       busy2, done2, pass2, fv2, ffa2, ffb2;
    logic [7:0] err2;
    assign out2 = a2 | b2;

    gate_sweep_checker #(.WIDTH(1), .OP(1), .SETTLE(0), .CNT_W(8)) u2 (
        .clock(clock), .reset(reset), .start(start2),
        .dut_a(a2), .dut_b(b2), .dut_out(out2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .fail_valid(fv2), .first_fail_a(ffa2), .first_fail_b(ffb2)
    );

    // u3: WIDTH=2, OP=OR, SETTLE=2, CNT_W=2, gate always returns ~expected
    logic       start3;
    logic [1:0] a3, b3, out3, ffa3, ffb3;
    logic       busy3, done3, pass3, fv3;
    logic [1:0] err3;
    assign out3 = ~(a3 | b3);

    gate_sweep_checker #(.WIDTH(2), .OP(1), .SETTLE(2), .CNT_W(2)) u3 (
        .clock(clock), .reset(reset), .start(start3),
        .dut_a(a3), .dut_b(b3), .dut_out(out3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .fail_valid(fv3), .first_fail_a(ffa3), .first_fail_b(ffb3)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        vectors++;
        if ({busy0, done0, pass0, fv0, ffa0, ffb0, a0, b0} !== 8'h00 || err0 !== 8'd0) begin
            $display("FAIL reset_outputs: got busy=%b done=%b pass=%b fv=%b ff=%b%b ab=%b%b err=%0d, want all 0",
                     busy0, done0, pass0, fv0, ffa0, ffb0, a0, b0, err0);
            miscompares++;
        end
    endtask

    // Full sweep on u0 with correct OR gate: edge-by-edge operand order and done timing.
    task automatic test_or_pass();
        logic [1:0] want;
        mode0  = 0;
        start0 = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick();
            start0 = 1'b0;
            want = (k <= 16) ? 2'((k - 1) / 4) : 2'd3;
            vectors++;
            if ({a0, b0} !== want || busy0 !== (k < 17) || done0 !== (k == 17)) begin
                $display("FAIL or_sweep_edge%0d: got ab=%b busy=%b done=%b, want ab=%b busy=%b done=%b",
                         k, {a0, b0}, busy0, done0, want, k < 17, k == 17);
                miscompares++;
            end
        end
        vectors++;
        if (pass0 !== 1'b1 || err0 !== 8'd0 || fv0 !== 1'b0) begin
            $display("FAIL or_result: got pass=%b err=%0d fv=%b, want pass=1 err=0 fv=0", pass0, err0, fv0);
            miscompares++;
        end
    endtask

    task automatic test_stuck_zero();
        mode0  = 1;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        vectors++;
        if (done0 !== 1'b0 || busy0 !== 1'b1 || err0 !== 8'd0) begin
            $display("FAIL restart_from_done: got done=%b busy=%b err=%0d, want done=0 busy=1 err=0",
                     done0, busy0, err0);
            miscompares++;
        end
        repeat (16) tick();
        vectors++;
        if (done0 !== 1'b1 || err0 !== 8'd3 || ffa0 !== 1'b0 || ffb0 !== 1'b1 ||
            pass0 !== 1'b0 || fv0 !== 1'b1) begin
            $display("FAIL stuck0_result: got done=%b err=%0d ff=(%b,%b) pass=%b fv=%b, want 1 3 (0,1) 0 1",
                     done0, err0, ffa0, ffb0, pass0, fv0);
            miscompares++;
        end
    endtask

    task automatic test_and_gate();
        mode0  = 2;
        start0 = 1'b1;
        start1 = 1'b1;
        tick();
        start0 = 1'b0;
        start1 = 1'b0;
        repeat (16) tick();
        vectors++;
        if (done0 !== 1'b1 || err0 !== 8'd2 || ffa0 !== 1'b0 || ffb0 !== 1'b1 || pass0 !== 1'b0) begin
            $display("FAIL and_vs_or: got done=%b err=%0d ff=(%b,%b) pass=%b, want 1 2 (0,1) 0",
                     done0, err0, ffa0, ffb0, pass0);
            miscompares++;
        end
        vectors++;
        if (done1 !== 1'b1 || pass1 !== 1'b1 || err1 !== 8'd0 || fv1 !== 1'b0) begin
            $display("FAIL and_vs_and: got done=%b pass=%b err=%0d fv=%b, want 1 1 0 0",
                     done1, pass1, err1, fv1);
            miscompares++;
        end
    endtask

    task automatic test_reset_mid();
        mode0  = 1;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (4) tick();
        reset  = 1'b1;
        start0 = 1'b1;
        tick();
        reset  = 1'b0;
        start0 = 1'b0;
        vectors++;
        if ({busy0, done0, pass0, fv0, ffa0, ffb0, a0, b0} !== 8'h00 || err0 !== 8'd0) begin
            $display("FAIL reset_mid_sweep: got busy=%b done=%b pass=%b fv=%b ab=%b%b err=%0d, want all 0",
                     busy0, done0, pass0, fv0, a0, b0, err0);
            miscompares++;
        end
        tick();
        vectors++;
        if (busy0 !== 1'b0) begin
            $display("FAIL reset_stays_idle: got busy=%b, want 0", busy0);
            miscompares++;
        end
        mode0  = 0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (15) tick();
        vectors++;
        if (done0 !== 1'b0) begin
            $display("FAIL post_reset_edge16: got done=%b, want 0", done0);
            miscompares++;
        end
        tick();
        vectors++;
        if (done0 !== 1'b1 || pass0 !== 1'b1 || err0 !== 8'd0 || fv0 !== 1'b0) begin
            $display("FAIL post_reset_result: got done=%b pass=%b err=%0d fv=%b, want 1 1 0 0",
                     done0, pass0, err0, fv0);
            miscompares++;
        end
    endtask

    task automatic test_start_held();
        logic [1:0] want;
        int         budget;
        mode0  = 1;
        start0 = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            tick();
            if (k < 17) begin
                want = 2'((k - 1) / 4);
                vectors++;
                if ({a0, b0} !== want || busy0 !== 1'b1) begin
                    $display("FAIL held_no_restart_edge%0d: got ab=%b busy=%b, want ab=%b busy=1",
                             k, {a0, b0}, busy0, want);
                    miscompares++;
                end
            end else if (k == 17) begin
                vectors++;
                if (done0 !== 1'b1 || err0 !== 8'd3) begin
                    $display("FAIL held_done: got done=%b err=%0d, want done=1 err=3", done0, err0);
                    miscompares++;
                end
            end else begin
                vectors++;
                if (done0 !== 1'b0 || busy0 !== 1'b1 || err0 !== 8'd0 || {a0, b0} !== 2'b00) begin
                    $display("FAIL held_restart: got done=%b busy=%b err=%0d ab=%b, want 0 1 0 00",
                             done0, busy0, err0, {a0, b0});
                    miscompares++;
                end
            end
        end
        start0 = 1'b0;
        budget = 0;
        while (done0 !== 1'b1 && budget < 40) begin
            tick();
            budget++;
        end
        vectors++;
        if (done0 !== 1'b1) begin
            $display("FAIL held_drain_timeout: got done=%b after %0d edges, want 1", done0, budget);
            miscompares++;
        end

        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        repeat (7) tick();
        vectors++;
        if (done2 !== 1'b0 || busy2 !== 1'b1) begin
            $display("FAIL settle0_edge8: got done=%b busy=%b, want done=0 busy=1", done2, busy2);
            miscompares++;
        end
        tick();
        vectors++;
        if (done2 !== 1'b1 || pass2 !== 1'b1 || err2 !== 8'd0) begin
            $display("FAIL settle0_edge9: got done=%b pass=%b err=%0d, want 1 1 0", done2, pass2, err2);
            miscompares++;
        end
    endtask

    task automatic test_wide_saturate();
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        repeat (3) tick();
        vectors++;
        if (err3 !== 2'd0) begin
            $display("FAIL wide_err_edge4: got %0d, want 0", err3);
            miscompares++;
        end
        tick();
        vectors++;
        if (err3 !== 2'd1 || fv3 !== 1'b1 || ffa3 !== 2'd0 || ffb3 !== 2'd0) begin
            $display("FAIL wide_first_fail: got err=%0d fv=%b ff=(%0d,%0d), want 1 1 (0,0)",
                     err3, fv3, ffa3, ffb3);
            miscompares++;
        end
        repeat (12) tick();
        vectors++;
        if (err3 !== 2'd3 || {a3, b3} !== 4'd4) begin
            $display("FAIL wide_saturate_edge17: got err=%0d ab=%0d, want err=3 ab=4", err3, {a3, b3});
            miscompares++;
        end
        repeat (47) tick();
        vectors++;
        if (done3 !== 1'b0) begin
            $display("FAIL wide_edge64: got done=%b, want 0", done3);
            miscompares++;
        end
        tick();
        vectors++;
        if (done3 !== 1'b1 || err3 !== 2'd3 || pass3 !== 1'b0 || fv3 !== 1'b1 ||
            ffa3 !== 2'd0 || ffb3 !== 2'd0 || {a3, b3} !== 4'hF) begin
            $display("FAIL wide_result: got done=%b err=%0d pass=%b fv=%b ff=(%0d,%0d) ab=%h, want 1 3 0 1 (0,0) f",
                     done3, err3, pass3, fv3, ffa3, ffb3, {a3, b3});
            miscompares++;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        start0      = 1'b0;
        start1      = 1'b0;
        start2      = 1'b0;
        start3      = 1'b0;
        mode0       = 0;
        #2;
        test_reset();
        test_or_pass();
        test_stuck_zero();
        test_and_gate();
        test_reset_mid();
        test_start_held();
        test_wide_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gate_sweep_checker.md
Name: gate_sweep_checker

Overview:
- Synthesizable stimulus/response checker for a 2-input bitwise gate under test.
- Sweeps every operand combination onto the gate inputs and waits a programmable settle time.
- Samples the gate output and compares it against the expected function.
- Reports pass/fail, a saturating error count and the first failing vector.
- Pairs with the team's gate modules; usable in simulation benches and on-board self-test.

Parameters:
- WIDTH, 1, operand width in bits for a and b; sweep covers 2^(2*WIDTH) vectors.
- OP, 1, expected function: 0=AND, 1=OR, 2=XOR, 3=NAND. Other values are treated as OR.
- SETTLE, 2, wait cycles between driving a vector and sampling; 0 is legal.
- CNT_W, 8, width of the error counter.

Ports:
- clock  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level-sampled run request; honoured only in IDLE or DONE.
- dut_a  out  WIDTH  registered operand a driven to the gate.
- dut_b  out  WIDTH  registered operand b driven to the gate.
- dut_out  in  WIDTH  gate output under test.
- busy  out  1  high while a sweep is in progress.
- done  out  1  high in DONE; held until the next run or reset.
- pass  out  1  valid when done=1; 1 iff err_count==0.
- err_count  out  CNT_W  number of mismatching vectors, saturating.
- fail_valid  out  1  high once first_fail_a/first_fail_b have been captured.
- first_fail_a  out  WIDTH  operand a of the first mismatching vector.
- first_fail_b  out  WIDTH  operand b of the first mismatching vector.

Behaviour:
- Clock and reset: one clock `clock`; reset `reset` is synchronous and active-high.
- Reset: on any edge with reset=1, state→IDLE and every output is 0, including dut_a/dut_b. Reset mid-sweep aborts immediately; no partial result is retained.
- Vector counter: vec is 2*WIDTH bits, {a,b}, with a in the upper half. dut_a/dut_b are registered copies of vec.
- IDLE: busy=0, done=0. On start=1, the next state is DRIVE, with:
  - vec=0 and dut_a=dut_b=0;
  - err_count=0, fail_valid=0, first_fail cleared;
  - busy=1.
- DRIVE: 1 cycle, operands stable. Next state is SETTLE if SETTLE>0, else SAMPLE.
- SETTLE: counts SETTLE cycles, then → SAMPLE. Operands are held throughout.
- SAMPLE: 1 cycle. exp = f_OP(dut_a,dut_b) computed bitwise across WIDTH. A mismatch is defined as dut_out != exp on any bit. On a mismatch:
  - err_count increments, saturating at 2^CNT_W-1;
  - if fail_valid=0, capture first_fail_a/b and set fail_valid=1.
- Leaving SAMPLE:
  - if vec is all ones → DONE;
  - else vec+1, operands updated on the same edge, → DRIVE.
- Per-vector cost is SETTLE+2 cycles. Total from the start-sampling edge to done=1 is N*(SETTLE+2)+1 edges, where N=2^(2*WIDTH).
- DONE: busy=0, done=1, pass=(err_count==0). err_count, fail_valid and first_fail are held. dut_a/dut_b hold the last vector. start=1 restarts exactly as from IDLE; done drops on that edge.
- start during DRIVE/SETTLE/SAMPLE is ignored; the sweep is never restarted mid-run.
- Simultaneous reset and start: reset wins.
- Counting an error and saturating on the same edge: err_count stays at max; first_fail capture is unaffected.
- dut_out is sampled only in SAMPLE; values at all other times are don't-care. X on dut_out counts as a mismatch in simulation.

Test Plan:
1. Correct OR gate, OP=1, WIDTH=1, SETTLE=2, 1-cycle start pulse → busy=1 next edge; vectors (0,0),(0,1),(1,0),(1,1) in order, 4 cycles each; done=1 at edge 17; pass=1, err_count=0, fail_valid=0.
2. dut_out stuck at 0, OP=1 → err_count=3, first_fail_a=0, first_fail_b=1, pass=0, fail_valid=1.
3. AND gate connected, OP=1 (gate/function mismatch) → err_count=2 (vectors (0,1),(1,0)), first_fail=(0,1); same gate with OP=0 → pass=1.
4. reset=1 for one edge at cycle 6 of a sweep → all outputs 0 on that edge, state IDLE. A following start runs the full 16-cycle sweep with fresh counts.
5. start held high throughout → no restart while busy; in DONE, restarts on the next edge, clears err_count, done falls. SETTLE=0 variant finishes at edge 9.
6. WIDTH=2, CNT_W=2, dut_out=~exp always → 16 vectors, err_count saturates at 3, first_fail=(0,0); done at 16*4+1=65 edges.
